// File: rtl/llr_rev_loader_pkg.sv
// Shared types and sizes for the SISO decoder LLR front end.
// Package siso_pkg: address/word widths, block limits, FSM states,
// LLR word type and the skid buffer entry payload.
package siso_pkg;

  localparam int unsigned ADDR_W   = 13;
  localparam int unsigned LLR_W    = 16;
  localparam int unsigned K_MAX    = 6144;
  localparam int unsigned TAIL_LEN = 3;

  typedef logic signed [LLR_W-1:0] llr_t;
  typedef logic [ADDR_W-1:0]       addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // One reversed word waiting for the downstream consumer.
  typedef struct packed {
    llr_t llr;
    logic last;
  } skid_ent_t;

endpackage

// File: rtl/llr_rev_loader_if.sv
// Stream bundle of the LLR loader.
//   s_valid/s_ready/s_llr : incoming channel LLRs (producer -> loader)
//   m_valid/m_ready/m_llr/m_last : reversed LLRs (loader -> consumer)
// Modport slave is the loader side, master is the environment side.
interface llr_rev_loader_if;
  import siso_pkg::*;

  logic s_valid;
  logic s_ready;
  llr_t s_llr;
  logic m_valid;
  logic m_ready;
  llr_t m_llr;
  logic m_last;

  modport slave  (input  s_valid, s_llr, m_ready,
                  output s_ready, m_valid, m_llr, m_last);
  modport master (output s_valid, s_llr, m_ready,
                  input  s_ready, m_valid, m_llr, m_last);
endinterface

// File: rtl/llr_rev_loader_skid_buf.sv
// llr_skid_buf: 2-entry FIFO of {llr, last} that absorbs the 1-cycle RAM
// read latency. Entry 0 is always the head, so the head is a register.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : write push_ent_i (never while full)
//   pop_i        : drop the head (only while not empty)
//   head_o       : head entry
//   count_o      : occupancy 0..2
module llr_skid_buf
  import siso_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  skid_ent_t push_ent_i,
  input  logic      pop_i,
  output skid_ent_t head_o,
  output logic [1:0] count_o
);

  skid_ent_t  ent0_q, ent1_q;
  logic [1:0] cnt_q;

  // Entry shift/fill; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= push_ent_i;
          else               ent1_q <= push_ent_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_q <= push_ent_i;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_ent_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/llr_rev_loader.sv
// llr_rev_loader: writes one block of K+3 LLRs into the decoder LLR RAM at
// ascending addresses, then replays it in descending address order.
//   clk, rst_n          : clock, async active-low reset
//   start, blk_len      : block start pulse and K (1..K_MAX), taken in IDLE
//   bus (slave)         : input LLR stream and reversed output stream
//   ram_we/addr/di/dout : RAM port, 1-cycle synchronous read
//   busy                : not IDLE
//   len_err             : sticky illegal-blk_len flag, cleared by a legal start
// Build option: define LLR_SAT_EN to clip written LLRs to +/-LLR_MAX.
module llr_rev_loader
  import siso_pkg::*;
`ifdef LLR_SAT_EN
  #(parameter int LLR_MAX = 32767)
`endif
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      blk_len,
  llr_rev_loader_if.slave        bus,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output llr_t                   ram_di,
  input  llr_t                   ram_dout,
  output logic                   busy,
  output logic                   len_err
);

  state_e     state_q, state_d;
  addr_t      n_q, n_d;
  addr_t      wr_cnt_q, wr_cnt_d;
  addr_t      rd_cnt_q, rd_cnt_d;
  logic       rd_done_q, rd_done_d;
  logic       infl_q, infl_d;
  logic       infl_last_q, infl_last_d;
  logic       len_err_q, len_err_d;

  logic       wr_hs, rd_issue, pop, start_ok;
  logic [1:0] skid_cnt, occ;
  skid_ent_t  head, push_ent;
  llr_t       wr_data;

`ifdef LLR_SAT_EN
  localparam llr_t SAT_HI = LLR_W'(LLR_MAX);
  localparam llr_t SAT_LO = LLR_W'(-LLR_MAX);

  // Clip the incoming word into the symmetric range.
  always_comb begin
    wr_data = bus.s_llr;
    if (bus.s_llr > SAT_HI)      wr_data = SAT_HI;
    else if (bus.s_llr < SAT_LO) wr_data = SAT_LO;
  end
`else
  assign wr_data = bus.s_llr;
`endif

  assign start_ok = (blk_len != '0) && (blk_len <= ADDR_W'(K_MAX));
  assign wr_hs    = (state_q == LOAD) && bus.s_valid;
  assign pop      = bus.m_valid && bus.m_ready;
  // Words already owned or on their way: read only if the buffer can take one more.
  assign occ      = skid_cnt + 2'(infl_q);
  assign rd_issue = (state_q == DRAIN) && !rd_done_q && (occ < (2'd2 + 2'(pop)));

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_done_d   = rd_done_q;
    len_err_d   = len_err_q;
    infl_d      = rd_issue;
    infl_last_d = rd_issue && (rd_cnt_q == '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            n_d       = blk_len + ADDR_W'(TAIL_LEN);
            wr_cnt_d  = '0;
            len_err_d = 1'b0;
            state_d   = LOAD;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (wr_hs) begin
          wr_cnt_d = wr_cnt_q + addr_t'(1);
          if (wr_cnt_q == n_q - addr_t'(1)) begin
            state_d   = DRAIN;
            rd_cnt_d  = n_q - addr_t'(1);
            rd_done_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (rd_issue) begin
          if (rd_cnt_q == '0) rd_done_d = 1'b1;
          else                rd_cnt_d  = rd_cnt_q - addr_t'(1);
        end
        if (pop && head.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      rd_done_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_done_q   <= rd_done_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      len_err_q   <= len_err_d;
    end
  end

  // Read data lands one cycle after its issue; tag the word from address 0.
  assign push_ent.llr  = ram_dout;
  assign push_ent.last = infl_last_q;

  llr_skid_buf u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (infl_q),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (skid_cnt)
  );

  assign bus.s_ready = (state_q == LOAD);
  assign bus.m_valid = (skid_cnt != 2'd0);
  assign bus.m_llr   = head.llr;
  assign bus.m_last  = head.last;

  assign ram_we   = wr_hs;
  assign ram_addr = wr_hs ? wr_cnt_q : (rd_issue ? rd_cnt_q : '0);
  assign ram_di   = wr_hs ? wr_data : '0;
  assign busy     = (state_q != IDLE);
  assign len_err  = len_err_q;

endmodule
